// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard scheduler.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage core: load-use stalls, branch flushes,
// and whole-pipeline freeze while data memory is busy, with a wait timeout.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ID_rs_i,
  input  logic [4:0]       ID_rt_i,
  input  logic             ID_uses_rt_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rt_i,
  input  logic             ID_branch_taken_i,
  input  logic             MEM_req_i,
  input  logic             dmem_ready_i,
  input  logic             clr_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_Flush_o,
  output logic             ID_EX_bubble_o,
  output logic             pipe_en_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  hz_state_e        state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             load_use;
  logic             freeze;

  assign load_use = EX_MemRead_i && (EX_rt_i != 5'd0) &&
                    ((EX_rt_i == ID_rs_i) || (ID_uses_rt_i && (EX_rt_i == ID_rt_i)));

  assign freeze = ((state_q == RUN) && MEM_req_i && !dmem_ready_i) ||
                  ((state_q == MEM_WAIT) && !dmem_ready_i) ||
                  (state_q == ERROR);

  assign err_o = (state_q == ERROR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ERROR ignores dmem_ready_i; only clr_i releases it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (MEM_req_i && !dmem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ERROR: begin
        if (clr_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Freeze beats load-use, which beats a taken branch; reset forces all low.
  always_comb begin
    PC_Write_o     = 1'b0;
    IF_ID_Write_o  = 1'b0;
    IF_Flush_o     = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_en_o      = 1'b0;
    if (rst_n_i && !freeze) begin
      pipe_en_o = 1'b1;
      if (load_use) begin
        ID_EX_bubble_o = 1'b1;
      end else begin
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_Flush_o    = ID_branch_taken_i;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc     (freeze || load_use),
    .clr     (clr_i),
    .cnt     (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc     (IF_Flush_o),
    .clr     (clr_i),
    .cnt     (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares every cycle.
module tb_hazard_ctrl;

  localparam logic [5:0] C_NORM  = 6'b110010;
  localparam logic [5:0] C_LU    = 6'b000110;
  localparam logic [5:0] C_FLUSH = 6'b111010;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_ERR   = 6'b000001;

  typedef struct {
    int         id;
    logic [5:0] ctrl;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  logic       clk_i;
  logic       rst_n_i;
  logic [4:0] ID_rs_i, ID_rt_i, EX_rt_i;
  logic       ID_uses_rt_i, EX_MemRead_i, ID_branch_taken_i;
  logic       MEM_req_i, dmem_ready_i, clr_i;
  logic       PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_bubble_o, pipe_en_o, err_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  exp_t       sb[$];
  int         total;
  int         bad;
  int         vec_id;
  logic [3:0] m_stall;
  logic [3:0] m_flush;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .ID_rs_i           (ID_rs_i),
    .ID_rt_i           (ID_rt_i),
    .ID_uses_rt_i      (ID_uses_rt_i),
    .EX_MemRead_i      (EX_MemRead_i),
    .EX_rt_i           (EX_rt_i),
    .ID_branch_taken_i (ID_branch_taken_i),
    .MEM_req_i         (MEM_req_i),
    .dmem_ready_i      (dmem_ready_i),
    .clr_i             (clr_i),
    .PC_Write_o        (PC_Write_o),
    .IF_ID_Write_o     (IF_ID_Write_o),
    .IF_Flush_o        (IF_Flush_o),
    .ID_EX_bubble_o    (ID_EX_bubble_o),
    .pipe_en_o         (pipe_en_o),
    .err_o             (err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counter expectations: stall cycles are those where PC write is expected low.
  task automatic applyStimulus(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic memread, input logic [4:0] ex_rt,
                               input logic br, input logic req, input logic ready,
                               input logic clr, input logic [5:0] exp_ctrl);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_n_i           = rst_n;
    ID_rs_i           = rs;
    ID_rt_i           = rt;
    ID_uses_rt_i      = uses_rt;
    EX_MemRead_i      = memread;
    EX_rt_i           = ex_rt;
    ID_branch_taken_i = br;
    MEM_req_i         = req;
    dmem_ready_i      = ready;
    clr_i             = clr;
    if (!rst_n) begin
      m_stall = 4'd0;
      m_flush = 4'd0;
    end
    e.id    = vec_id;
    e.ctrl  = exp_ctrl;
    e.stall = m_stall;
    e.flush = m_flush;
    sb.push_back(e);
    vec_id++;
    if (rst_n) begin
      if (clr) begin
        m_stall = 4'd0;
        m_flush = 4'd0;
      end else begin
        if (!exp_ctrl[5] && m_stall != 4'hF) m_stall = m_stall + 4'd1;
        if (exp_ctrl[3] && m_flush != 4'hF) m_flush = m_flush + 4'd1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] got;
    got = {PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_bubble_o, pipe_en_o, err_o};
    total++;
    if (got !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL vec%0d ctrl{pc,ifid,flush,bubble,pipe,err}: got %b want %b", e.id, got, e.ctrl);
    end
    total++;
    if (stall_cnt_o !== e.stall) begin
      bad++;
      $display("[TB] FAIL vec%0d stall_cnt: got %0d want %0d", e.id, stall_cnt_o, e.stall);
    end
    total++;
    if (flush_cnt_o !== e.flush) begin
      bad++;
      $display("[TB] FAIL vec%0d flush_cnt: got %0d want %0d", e.id, flush_cnt_o, e.flush);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0; bad = 0; vec_id = 0;
    m_stall = 4'd0; m_flush = 4'd0;
    rst_n_i = 1'b0;
    ID_rs_i = 5'd1; ID_rt_i = 5'd2; ID_uses_rt_i = 1'b0;
    EX_MemRead_i = 1'b0; EX_rt_i = 5'd0; ID_branch_taken_i = 1'b0;
    MEM_req_i = 1'b0; dmem_ready_i = 1'b1; clr_i = 1'b0;

    //            rst rs  rt  urt mr  exrt br  req rdy clr  expect
    applyStimulus(0, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_FRZ);   // reset held
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_NORM);
    applyStimulus(1, 9,  2,  0,  1,  9,  0,  0,  1,  0,  C_LU);    // load-use on rs
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_NORM);
    applyStimulus(1, 0,  2,  0,  1,  0,  0,  0,  1,  0,  C_NORM);  // $zero dest
    applyStimulus(1, 1,  9,  0,  1,  9,  0,  0,  1,  0,  C_NORM);  // rt not used
    applyStimulus(1, 1,  9,  1,  1,  9,  0,  0,  1,  0,  C_LU);    // rt used
    applyStimulus(1, 1,  2,  0,  0,  0,  1,  0,  1,  0,  C_FLUSH); // taken branch
    applyStimulus(1, 9,  2,  0,  1,  9,  1,  0,  1,  0,  C_LU);    // branch + load-use
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  1,  C_NORM);  // clear counters
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  1,  1,  0,  C_NORM);  // mem ready first cycle
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  1,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  1,  1,  0,  0,  C_FRZ);
    applyStimulus(1, 9,  2,  0,  1,  9,  0,  1,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  1,  1,  0,  C_NORM);  // ready: advance
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_NORM);  // back in RUN
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  1,  C_NORM);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_NORM);
    // timeout: RUN + 4 MEM_WAIT frozen cycles, then ERROR
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  1,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  1,  0,  0,  0,  C_FRZ);
    applyStimulus(1, 9,  2,  0,  1,  9,  0,  0,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_ERR);   // ready ignored
    applyStimulus(1, 9,  2,  0,  1,  9,  1,  0,  1,  0,  C_ERR);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  1,  C_ERR);   // clr leaves ERROR
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_NORM);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 9, 2, 0, 1, 9, 0, 0, 1, 0, C_LU);
    end
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  1,  0,  C_NORM);  // saturated at 15
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  1,  0,  0,  C_FRZ);
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_FRZ);
    applyStimulus(0, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_FRZ);   // reset mid-wait
    applyStimulus(1, 1,  2,  0,  0,  0,  0,  0,  0,  0,  C_NORM);  // RUN after release
    applyStimulus(1, 1,  2,  0,  0,  0,  1,  0,  1,  0,  C_FLUSH);

    @(negedge clk_i);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard scheduler for the 5-stage core: decides each cycle whether the IF/ID pipeline register and PC advance, hold, or flush, and whether ID/EX receives a bubble. Detects load-use hazards, sequences taken-branch flushes, and freezes the whole pipeline while the data memory is busy, with a wait-timeout error state. Drives `IF_ID_Write_i`/`IF_Flush_i` of the IF/ID register, the PC write enable, the ID/EX bubble mux and a global pipeline enable; keeps saturating stall/flush performance counters.

## Interface
- `TIMEOUT`, 64: maximum consecutive memory-wait cycles before ERROR (≥1).
- `CNT_W`, 32: width of performance counters.
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset; one clock, asynchronous, active-low.
- `ID_rs_i` in 5: rs field of instruction in ID.
- `ID_rt_i` in 5: rt field of instruction in ID.
- `ID_uses_rt_i` in 1: ID instruction reads rt as a source.
- `EX_MemRead_i` in 1: instruction in EX is a load.
- `EX_rt_i` in 5: destination of the load in EX.
- `ID_branch_taken_i` in 1: branch resolved taken in ID.
- `MEM_req_i` in 1: MEM stage holds a load/store.
- `dmem_ready_i` in 1: data memory completes access this cycle.
- `clr_i` in 1: synchronous clear of counters and ERROR.
- `PC_Write_o` out 1: PC register write enable.
- `IF_ID_Write_o` out 1: IF/ID write enable.
- `IF_Flush_o` out 1: IF/ID flush (zero) request.
- `ID_EX_bubble_o` out 1: zero ID/EX control fields.
- `pipe_en_o` out 1: write enable for ID/EX, EX/MEM, MEM/WB.
- `err_o` out 1: memory-timeout error (state ERROR).
- `stall_cnt_o` out CNT_W: stalled cycles.
- `flush_cnt_o` out CNT_W: flush cycles.

## Operation
- `load_use` = `EX_MemRead_i` & (`EX_rt_i`≠0) & ((`EX_rt_i`==`ID_rs_i`) | (`ID_uses_rt_i` & `EX_rt_i`==`ID_rt_i`)).
- `freeze` = (RUN & `MEM_req_i` & ~`dmem_ready_i`) | (MEM_WAIT & ~`dmem_ready_i`) | ERROR.
- Output priority, combinational (Mealy):
  - `freeze`: `PC_Write_o`=0, `IF_ID_Write_o`=0, `pipe_en_o`=0, flush=0, bubble=0.
  - else `load_use`: PC/IF_ID write 0, `ID_EX_bubble_o`=1, `pipe_en_o`=1, flush=0; `ID_branch_taken_i` ignored.
  - else `ID_branch_taken_i`: `IF_Flush_o`=1, PC/IF_ID write 1, `pipe_en_o`=1, bubble=0.
  - else: PC/IF_ID write 1, `pipe_en_o`=1, flush=0, bubble=0.
- FSM states RUN, MEM_WAIT, ERROR; `wait_cnt` width clog2(TIMEOUT+1):
  - RUN: `MEM_req_i` & ~`dmem_ready_i` → MEM_WAIT, `wait_cnt`←1.
  - MEM_WAIT: `dmem_ready_i` → RUN, `wait_cnt`←0; else `wait_cnt`==TIMEOUT → ERROR; else `wait_cnt`++.
  - ERROR: `err_o`=1; `clr_i` → RUN, `wait_cnt`←0.
- `clr_i` outside ERROR: clears counters only; state unaffected.
- `stall_cnt_o` +1 per cycle with `freeze` | `load_use`; `flush_cnt_o` +1 per cycle with `IF_Flush_o`. Both saturate at all-ones; `clr_i` wins over same-cycle increment.

## Timing
- Reset (`rst_n_i`=0, asynchronous): state RUN, `wait_cnt`=0, counters 0, `err_o`=0; while asserted all enables, flush and bubble forced 0.
- Control outputs zero latency from inputs; state/counters update on rising edge.
- Memory access completing first cycle (ready with req in RUN): no stall.
- Cycle where MEM_WAIT sees `dmem_ready_i`=1: `freeze`=0, pipeline advances that same cycle.
- Load-use stall: exactly 1 cycle (load leaves EX next edge).
- ERROR entered after TIMEOUT+1 frozen cycles; held until `clr_i`, even if `dmem_ready_i` rises.
- Reset mid-MEM_WAIT: immediate return to RUN, no pending state.

## Structure
- Package `hazard_pkg`: state enum (RUN, MEM_WAIT, ERROR), default TIMEOUT/CNT_W constants.
- Sub-module `sat_counter` (width parameter, inc, clr, async active-low reset), instantiated twice.

## Test plan
- Reset then load `$t1` in EX (`EX_rt_i`=9), ID rs=9 → 1 cycle PC/IF_ID write 0, bubble 1, `stall_cnt_o`=1.
- Load with `EX_rt_i`=0, ID rs=0 → no stall; `ID_uses_rt_i`=0 with rt match → no stall.
- Branch taken, no hazard → `IF_Flush_o`=1, writes 1, `flush_cnt_o`=1; branch with concurrent load-use → stall, no flush.
- `MEM_req_i`=1, ready low 3 cycles then high → freeze 3 cycles, advance on 4th, `stall_cnt_o`=3, state RUN.
- TIMEOUT=4, ready never rises → ERROR after 5 frozen cycles, `err_o`=1; `clr_i` → RUN, counters 0.
- `CNT_W`=4, 20 stall cycles → `stall_cnt_o`=15; `rst_n_i` pulsed low mid-MEM_WAIT → all outputs 0 immediately, RUN after release.
